// File: rtl/cond_exec_ctrl.sv
// cond_exec_ctrl: NZCV flag register, condition evaluation and write-enable gating behind a valid/ready stage.
// Define COND_PERF_CNT_EN to add the exec_cnt/squash_cnt counters and the CNT_W parameter.
module cond_exec_ctrl #(
    parameter logic [3:0] RESET_FLAGS = 4'b0000
`ifdef COND_PERF_CNT_EN
    , parameter int CNT_W = 16
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] cond,
    input  logic [3:0] alu_flags,
    input  logic [1:0] flag_w,
    input  logic       pcs,
    input  logic       reg_w,
    input  logic       mem_w,
    input  logic       no_write,
    input  logic       flush,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_cond_ex,
    output logic       out_pcs,
    output logic       out_reg_w,
    output logic       out_mem_w,
    output logic [3:0] flags
`ifdef COND_PERF_CNT_EN
    , output logic [CNT_W-1:0] exec_cnt,
    output logic [CNT_W-1:0] squash_cnt
`endif
);
    logic [3:0] flags_q, flags_d, out_q, out_d;
    logic       valid_q, valid_d, base, cond_ex, accept, hold;

    assign in_ready = ~valid_q | out_ready;

    // Odd codes are the complement of the even code below them; 1111 is "never".
    always_comb begin
        base = 1'b1;
        case (cond[3:1])
            3'd0:    base = flags_q[2];
            3'd1:    base = flags_q[1];
            3'd2:    base = flags_q[3];
            3'd3:    base = flags_q[0];
            3'd4:    base = flags_q[1] & ~flags_q[2];
            3'd5:    base = flags_q[3] == flags_q[0];
            3'd6:    base = ~flags_q[2] & (flags_q[3] == flags_q[0]);
            default: base = 1'b1;
        endcase
        cond_ex       = (cond[3:1] == 3'b111) ? ~cond[0] : base ^ cond[0];
        accept        = in_valid & in_ready & ~flush;
        hold          = valid_q & ~out_ready & ~flush;
        valid_d       = accept | hold;
        out_d         = accept ? {cond_ex, pcs & cond_ex, reg_w & cond_ex & ~no_write, mem_w & cond_ex}
                      : hold   ? out_q : 4'b0000;
        flags_d[3:2]  = (accept & cond_ex & flag_w[1]) ? alu_flags[3:2] : flags_q[3:2];
        flags_d[1:0]  = (accept & cond_ex & flag_w[0]) ? alu_flags[1:0] : flags_q[1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_q <= RESET_FLAGS;
            out_q   <= 4'b0000;
            valid_q <= 1'b0;
        end else begin
            flags_q <= flags_d;
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    assign out_valid = valid_q;
    assign {out_cond_ex, out_pcs, out_reg_w, out_mem_w} = out_q;
    assign flags = flags_q;

`ifdef COND_PERF_CNT_EN
    logic [CNT_W-1:0] exec_q, squash_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exec_q   <= '0;
            squash_q <= '0;
        end else begin
            exec_q   <= exec_q + CNT_W'(accept & cond_ex);
            squash_q <= squash_q + CNT_W'(accept & ~cond_ex);
        end
    end

    assign exec_cnt   = exec_q;
    assign squash_cnt = squash_q;
`endif
endmodule

// File: doc/cond_exec_ctrl.md
Name: cond_exec_ctrl

Overview:
Registered conditional-execution controller for the processor datapath. Owns the architectural NZCV flag register and evaluates each instruction's 4-bit condition field against it. Gates the PCS/RegW/MemW control signals and advances one instruction per accepted transfer through a valid/ready stage. Sits between decode and the write-enable consumers (PC mux, register file, data memory).

Parameters:
RESET_FLAGS, 4'b0000, NZCV value loaded into the flag register on reset
CNT_W, 16, width of the performance counters (used only with COND_PERF_CNT_EN)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  instruction present on the input bus
in_ready  output  1  controller can accept this cycle
cond  input  4  instruction condition field Instr[31:28]
alu_flags  input  4  ALU result flags {N,Z,C,V}
flag_w  input  2  [1] update N,Z; [0] update C,V
pcs  input  1  instruction writes PC
reg_w  input  1  instruction writes register file
mem_w  input  1  instruction writes memory
no_write  input  1  compare-type op: suppress reg_w
flush  input  1  synchronous squash of the stage
out_valid  output  1  output stage holds an instruction
out_ready  input  1  downstream accepts output
out_cond_ex  output  1  condition passed for held instruction
out_pcs  output  1  pcs & cond_ex
out_reg_w  output  1  reg_w & cond_ex & ~no_write
out_mem_w  output  1  mem_w & cond_ex
flags  output  4  current flag register {N,Z,C,V}

Behaviour:
- Reset (async, immediate): flags=RESET_FLAGS; out_valid, out_cond_ex, out_pcs, out_reg_w, out_mem_w = 0.
- in_ready = ~out_valid | out_ready (combinational). accept = in_valid & in_ready & ~flush.
- Condition evaluated combinationally against the flag register (not alu_flags): 0000 EQ Z; 0001 NE ~Z; 0010 CS C; 0011 CC ~C; 0100 MI N; 0101 PL ~N; 0110 VS V; 0111 VC ~V; 1000 HI C&~Z; 1001 LS ~C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT ~Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1; 1111 treated as never (0).
- On accept, at the clock edge:
  - Output register loads gated controls and cond_ex; out_valid=1. Latency 1 cycle.
  - If cond_ex: flag_w[1] loads N,Z from alu_flags[3:2]; flag_w[0] loads C,V from alu_flags[1:0]. Failed conditions never modify flags.
- Back-to-back: instruction accepted at edge k+1 evaluates flags updated at edge k.
- Stall (out_valid & ~out_ready): all outputs and flags hold; in_ready=0.
- Output drained without a new accept: out_valid=0 next cycle; gated outputs forced to 0.
- flush=1: out_valid=0 and gated outputs=0 next cycle. Any input presented that cycle is discarded, with no flag update. Flag register retained. flush overrides stall.
- Outputs never assert out_pcs/out_reg_w/out_mem_w while out_valid=0.

Optional Feature:
COND_PERF_CNT_EN: adds outputs exec_cnt[CNT_W-1:0] and squash_cnt[CNT_W-1:0], both reset to 0.
- exec_cnt increments on accept with cond_ex=1.
- squash_cnt increments on accept with cond_ex=0.
- Both wrap modulo 2^CNT_W; neither counts flushed inputs.
Without the macro: neither the ports nor the counter logic exist; all other behaviour is identical.

Test Plan:
1. Reset with RESET_FLAGS=0, then cond=0000 (EQ), reg_w=1, in_valid=1, out_ready=1 -> next cycle out_valid=1, out_cond_ex=0, out_reg_w=0, flags=0000.
2. cond=1110 (AL), alu_flags=0100, flag_w=11, then cond=0000 (EQ) with reg_w=1 on the next cycle -> flags=0100 after the first edge; second instruction has out_cond_ex=1, out_reg_w=1.
3. flags=1001, cond=1010 (GE), mem_w=1 -> out_mem_w=1. Then cond=1011 (LT) with flag_w=11, alu_flags=0000 -> out_cond_ex=0 and flags remain 1001.
4. out_ready=0 for 3 cycles while holding an AL instruction -> in_ready=0, outputs and flags stable. With out_ready=1 and in_valid=0 -> out_valid=0 next cycle.
5. flush=1 together with in_valid=1, cond=1110, flag_w=11, alu_flags=1111 -> out_valid=0 next cycle; flags unchanged. Also assert reset mid-stall -> all outputs 0 immediately.
6. COND_PERF_CNT_EN with CNT_W=4: 17 AL instructions and 2 NV (1111) instructions -> exec_cnt=1 (wrapped), squash_cnt=2. cond=1111 with no_write=0, reg_w=1 -> out_reg_w=0.
